// File: rtl/rom_line_buffer_if.sv
// Request/response and Wishbone signal bundle for rom_line_buffer.
// slave: the line buffer side; master: the bus FSM / flash side.
interface rom_line_buffer_if #(
  parameter int ADDR_W = 22
);
  logic              i_inv;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_burst;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [3:0]        o_wb_sel;
  logic              i_wb_stall;
  logic              i_wb_ack;
  logic [31:0]       i_wb_data;

  modport slave (
    input  i_inv, req_valid, req_addr, req_burst,
    input  i_wb_stall, i_wb_ack, i_wb_data,
    output req_ready, rsp_valid, rsp_data,
    output rsp_last, rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_sel
  );

  modport master (
    output i_inv, req_valid, req_addr, req_burst,
    output i_wb_stall, i_wb_ack, i_wb_data,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_last, rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_sel
  );
endinterface

// File: rtl/rom_line_buffer.sv
// One-line (4 x 32-bit) ROM read buffer in front of an SPI flash reader.
// Ports: clk, rst (async, active-low), bus (req/rsp + Wishbone, slave).
module rom_line_buffer #(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rst,
  rom_line_buffer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, HIT, STB, WAIT, FEND, ERR
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-3:0] tag;
  logic [1:0]        w;
  logic [1:0]        cnt;
  logic [1:0]        word;
  logic              burst;
  logic              line_valid;
  logic              inv_seen;
  logic [TW-1:0]     tmo;
  logic [31:0]       lbuf [4];
  logic              fwd_valid;
  logic              fwd_last;
  logic [31:0]       fwd_data;
  logic              accept;
  logic              hit;
  logic              taken;
  logic              acked;
  logic              tmo_hit;

  assign word    = w + cnt;
  assign accept  = bus.req_valid && state == IDLE;
  assign hit     = line_valid && !bus.i_inv &&
                   tag == bus.req_addr[ADDR_W-1:2];
  assign taken   = state == STB && !bus.i_wb_stall;
  assign acked   = state == WAIT && bus.i_wb_ack;
  assign tmo_hit = state == WAIT && !bus.i_wb_ack &&
                   tmo == TW'(TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = hit ? HIT : STB;
      HIT:  if (!burst || cnt == 2'd3) nxt = IDLE;
      STB:  if (taken) nxt = WAIT;
      WAIT: begin
        if (acked)        nxt = (cnt == 2'd3) ? FEND : STB;
        else if (tmo_hit) nxt = ERR;
      end
      FEND: nxt = IDLE;
      ERR:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = state == IDLE;
    bus.o_wb_cyc  = state == STB || state == WAIT;
    bus.o_wb_stb  = state == STB;
    bus.o_wb_sel  = (state == STB) ? 4'hF : 4'h0;
    bus.o_wb_addr = (state == STB || state == WAIT) ?
                    {tag, word} : '0;
    bus.rsp_valid = fwd_valid;
    bus.rsp_data  = fwd_valid ? fwd_data : '0;
    bus.rsp_last  = fwd_valid && fwd_last;
    bus.rsp_err   = 1'b0;
    if (state == HIT) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = lbuf[word];
      bus.rsp_last  = !burst || cnt == 2'd3;
    end
    if (state == ERR) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hFFFF_FFFF;
      bus.rsp_last  = 1'b1;
      bus.rsp_err   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag        <= '0;
      w          <= '0;
      cnt        <= '0;
      burst      <= 1'b0;
      line_valid <= 1'b0;
      inv_seen   <= 1'b0;
      tmo        <= '0;
      fwd_valid  <= 1'b0;
      fwd_last   <= 1'b0;
      fwd_data   <= '0;
      for (int i = 0; i < 4; i++) lbuf[i] <= '0;
    end else begin
      fwd_valid <= 1'b0;
      fwd_last  <= 1'b0;
      if (accept) begin
        tag   <= bus.req_addr[ADDR_W-1:2];
        w     <= bus.req_addr[1:0];
        burst <= bus.req_burst;
        cnt   <= '0;
      end else if (state == HIT || acked) begin
        cnt <= cnt + 2'd1;
      end
      if (taken)             tmo <= '0;
      else if (state == WAIT) tmo <= tmo + TW'(1);
      if (acked) begin
        lbuf[word] <= bus.i_wb_data;
        fwd_data   <= bus.i_wb_data;
        // single reads forward only the critical word
        fwd_valid  <= burst || cnt == 2'd0;
        fwd_last   <= burst ? cnt == 2'd3 : cnt == 2'd0;
      end
      // an invalidate racing the accept is already a miss;
      // the fill that follows fetches fresh data
      if (accept)
        inv_seen <= 1'b0;
      else if (bus.o_wb_cyc && bus.i_inv)
        inv_seen <= 1'b1;
      if (acked && cnt == 2'd3)
        line_valid <= !(inv_seen || bus.i_inv);
      else if (bus.i_inv || (accept && !hit))
        line_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rom_line_buffer.sv
// Self-checking bench for rom_line_buffer.
// Flash model + Wishbone responder + abstract line-cache model.
module tb_rom_line_buffer;
  localparam int AW  = 22;
  localparam int TMO = 1023;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rom_line_buffer_if #(.ADDR_W(AW)) bus ();
  rom_line_buffer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
    int          c;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            burst;
    bit            inv;
    bit            exp_hit;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc_n = 0;
  logic [AW-1:0] wb_log [$];
  int take_log [$];
  int ack_log [$];
  int stb_log [$];
  beat_t beats [$];
  int stall_left;
  int ack_lat;
  bit no_ack;
  bit stray;
  bit m_valid;
  logic [AW-3:0] m_tag;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] flash(input logic [AW-1:0] a);
    return {10'h2B5, a} ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Wishbone flash responder
  initial begin
    int pend;
    int wait_n;
    int run;
    logic [AW-1:0] pa;
    pend = 0; wait_n = 0; run = 0; pa = '0;
    bus.i_wb_stall = 1'b0;
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_data  = '0;
    forever begin
      @(negedge clk);
      bus.i_wb_ack   = 1'b0;
      bus.i_wb_stall = 1'b0;
      if (!bus.o_wb_cyc) begin
        pend = 0;
        run  = 0;
        if (stray) begin
          bus.i_wb_ack  = 1'b1;
          bus.i_wb_data = 32'hDEAD_BEEF;
        end
      end else if (pend != 0) begin
        if (wait_n > 0) wait_n--;
        else if (!no_ack) begin
          bus.i_wb_ack  = 1'b1;
          bus.i_wb_data = flash(pa);
          ack_log.push_back(cyc_n);
          pend = 0;
        end
      end else if (bus.o_wb_stb) begin
        run++;
        if (stall_left > 0) begin
          bus.i_wb_stall = 1'b1;
          stall_left--;
        end else begin
          pend   = 1;
          pa     = bus.o_wb_addr;
          wait_n = ack_lat;
          wb_log.push_back(pa);
          take_log.push_back(cyc_n);
          stb_log.push_back(run);
          run = 0;
          chk("wb_sel", 64'(bus.o_wb_sel), 64'hF);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.rsp_valid)
      beats.push_back('{bus.rsp_data, bus.rsp_last,
                        bus.rsp_err, cyc_n});
  end

  task automatic run_req(input logic [AW-1:0] a,
                         input bit b,
                         input bit inv_acc,
                         input int inv_at,
                         input int stall_n,
                         input int lat,
                         input bit noack,
                         output bit hit_obs);
    bit exp_hit;
    bit inv_done;
    int t0;
    int g;
    int n;
    logic [AW-3:0] tg;
    logic [1:0] w;
    logic [1:0] wi;
    tg = a[AW-1:2];
    w  = a[1:0];
    exp_hit  = m_valid && m_tag == tg && !inv_acc;
    inv_done = 0;
    wb_log.delete(); take_log.delete(); ack_log.delete();
    stb_log.delete(); beats.delete();
    stall_left = stall_n; ack_lat = lat; no_ack = noack;
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_burst = b;
    bus.i_inv     = inv_acc;
    @(negedge clk);
    t0 = cyc_n;
    bus.req_valid = 1'b0;
    bus.i_inv     = 1'b0;
    g = 0;
    while (!bus.req_ready && g < TMO + 100) begin
      bus.i_inv = (g == inv_at);
      if (g == inv_at) inv_done = 1;
      @(negedge clk);
      g++;
    end
    bus.i_inv = 1'b0;
    #1;
    chk("req_complete", 64'(bus.req_ready), 64'd1);
    hit_obs = (wb_log.size() == 0);
    chk("hit", 64'(hit_obs), 64'(exp_hit));
    if (noack && !exp_hit) begin
      chk("tmo_reads", 64'(wb_log.size()), 64'd1);
      chk("tmo_beats", 64'(beats.size()), 64'd1);
      if (beats.size() > 0 && take_log.size() > 0) begin
        chk("tmo_beat", {beats[0].d, beats[0].l, beats[0].e},
            {32'hFFFF_FFFF, 1'b1, 1'b1});
        chk("tmo_cycle", 64'(beats[0].c),
            64'(take_log[0] + TMO + 1));
      end
      m_valid = 0;
      m_tag   = tg;
    end else begin
      n = b ? 4 : 1;
      chk("beat_count", 64'(beats.size()), 64'(n));
      if (!exp_hit) begin
        chk("wb_reads", 64'(wb_log.size()), 64'd4);
        if (stb_log.size() > 0)
          chk("stb_hold", 64'(stb_log[0]), 64'(stall_n + 1));
      end
      for (int i = 0; i < 4; i++) begin
        wi = w + 2'(i);
        if (!hit_obs && i < wb_log.size())
          chk("wb_addr", 64'(wb_log[i]), 64'({tg, wi}));
      end
      for (int i = 0; i < n && i < beats.size(); i++) begin
        wi = w + 2'(i);
        chk("beat", {beats[i].d, beats[i].l, beats[i].e},
            {flash({tg, wi}), i == n - 1, 1'b0});
        if (hit_obs)
          chk("hit_cycle", 64'(beats[i].c), 64'(t0 + i));
        else if (i < ack_log.size())
          chk("fwd_cycle", 64'(beats[i].c),
              64'(ack_log[i] + 1));
      end
      m_tag   = tg;
      m_valid = !inv_done;
    end
  endtask

  initial begin
    vec_t tbl [8];
    bit h;
    int g;
    logic [AW-3:0] tg_r;
    logic [AW-1:0] a;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_burst = 1'b0;
    bus.i_inv     = 1'b0;
    stall_left = 0; ack_lat = 0; no_ack = 0; stray = 0;
    m_valid = 0; m_tag = '0;
    tbl[0] = '{22'h000010, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{22'h000012, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{22'h000013, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{22'h000010, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{22'h000011, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{22'h000020, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{22'h000023, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{22'h000010, 1'b1, 1'b0, 1'b0};

    #12;
    chk("reset_ctl",
        {bus.req_ready, bus.rsp_valid, bus.rsp_last,
         bus.rsp_err, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_sel},
        10'b10_0000_0000);
    chk("reset_data", 64'(bus.rsp_data), 64'd0);
    chk("reset_addr", 64'(bus.o_wb_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].addr, tbl[i].burst, tbl[i].inv,
              -1, 0, 1, 0, h);
      chk("tbl_hit", 64'(h), 64'(tbl[i].exp_hit));
    end

    // idle invalidate, then stray acks while idle
    @(negedge clk); bus.i_inv = 1'b1;
    @(negedge clk); bus.i_inv = 1'b0;
    m_valid = 0;
    run_req(22'h000011, 1'b0, 1'b0, -1, 0, 0, 0, h);
    chk("inv_idle_miss", 64'(h), 64'd0);
    stray = 1;
    repeat (4) @(negedge clk);
    stray = 0;
    run_req(22'h000012, 1'b1, 1'b0, -1, 0, 0, 0, h);
    chk("stray_hit", 64'(h), 64'd1);

    // stalled burst miss with invalidate mid-fill
    run_req(22'h000105, 1'b1, 1'b0, 2, 3, 1, 0, h);
    chk("stall_miss", 64'(h), 64'd0);
    run_req(22'h000105, 1'b1, 1'b0, -1, 0, 0, 0, h);
    chk("inv_fill_miss", 64'(h), 64'd0);
    run_req(22'h000106, 1'b0, 1'b0, -1, 0, 0, 0, h);
    chk("refill_hit", 64'(h), 64'd1);

    // flash timeout, then the same line must miss
    run_req(22'h000200, 1'b1, 1'b0, -1, 0, 0, 1, h);
    run_req(22'h000201, 1'b0, 1'b0, -1, 0, 0, 0, h);
    chk("tmo_then_miss", 64'(h), 64'd0);

    // reset in the middle of a fill
    wb_log.delete(); ack_log.delete(); take_log.delete();
    stb_log.delete(); beats.delete();
    stall_left = 0; ack_lat = 2; no_ack = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 22'h000300;
    bus.req_burst = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    g = 0;
    while (ack_log.size() < 2 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("rst_two_acks", 64'(ack_log.size()), 64'd2);
    chk("rst_pre_cyc", 64'(bus.o_wb_cyc), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_cyc_stb", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b00);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    m_valid = 0;
    run_req(22'h000301, 1'b1, 1'b0, -1, 0, 0, 0, h);
    chk("rst_then_miss", 64'(h), 64'd0);

    // randomized traffic against the line model
    for (int k = 0; k < 50; k++) begin
      tg_r = 20'h00040 + 20'($urandom_range(0, 2));
      a    = {tg_r, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); bus.i_inv = 1'b1;
        @(negedge clk); bus.i_inv = 1'b0;
        m_valid = 0;
      end
      run_req(a, 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0,
              ($urandom_range(0, 5) == 0) ?
                int'($urandom_range(0, 5)) : -1,
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)),
              $urandom_range(0, 24) == 0, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end
endmodule
